// File: rtl/path_rle_encoder.sv
// Run-length encoder for the maze solver's direction stream.
// Emits (dir, len, last) tokens through a first-word fall-through FIFO.
module path_rle_encoder #(
  parameter int DIR_WIDTH  = 2,
  parameter int LEN_WIDTH  = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DIR_WIDTH-1:0] in_dir,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DIR_WIDTH-1:0] out_dir,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = 1 + DIR_WIDTH + LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = {LEN_WIDTH{1'b1}};
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DIR_WIDTH-1:0] cur_dir;
  logic [LEN_WIDTH-1:0] cur_len;

  logic          push;
  logic          load;
  logic          extend;
  logic [TW-1:0] push_tok;

  logic [TW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [TW-1:0] head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (!in_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    load     = 1'b0;
    extend   = 1'b0;
    push_tok = '0;
    unique case (state)
      IDLE: load = in_valid;
      RUN: begin
        if (!in_valid) begin
          push     = 1'b1;
          push_tok = {1'b1, cur_dir, cur_len};
        end else if (in_dir == cur_dir && cur_len != MAX_LEN) begin
          extend = 1'b1;
        end else begin
          // direction change or saturated run: close and restart
          push     = 1'b1;
          push_tok = {1'b0, cur_dir, cur_len};
          load     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dir <= '0;
      cur_len <= '0;
    end else if (load) begin
      cur_dir <= in_dir;
      cur_len <= LEN_WIDTH'(1);
    end else if (extend) begin
      cur_len <= cur_len + LEN_WIDTH'(1);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = !empty && out_ready;
  // a pop frees the head slot, so a full FIFO still takes the push
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_tok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = !empty;
  assign out_last  = empty ? 1'b0 : head[TW-1];
  assign out_dir   = empty ? '0 : head[TW-2 -: DIR_WIDTH];
  assign out_len   = empty ? '0 : head[LEN_WIDTH-1:0];
  assign busy      = (state == RUN) || !empty;

endmodule

// File: tb/tb_path_rle_encoder.sv
// Bench for path_rle_encoder: queue-based reference model
// checked every cycle, plus literal token lists per scenario.
module tb_path_rle_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_dir;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_dir;
  logic [4:0] out_len;
  logic       out_last;
  logic       overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  logic [1:0] run_q[$];
  bit         m_ov = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  path_rle_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_dir(in_dir),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_dir(out_dir),
    .out_len(out_len),
    .out_last(out_last),
    .overflow(overflow),
    .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] tk(input bit l, input int d, input int n);
    logic [1:0] dd;
    logic [4:0] nn;
    dd = 2'(d);
    nn = 5'(n);
    return {l, dd, nn};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the open run is the list of its beats; tokens go to a
  // bounded queue of 8 where a same-cycle pop makes room.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        run_q.delete();
        m_ov = 0;
      end else begin
        bit         do_push;
        bit         was_full;
        bit         do_pop;
        logic [7:0] t;
        do_push = 0;
        t = 0;
        if (in_valid) begin
          if (run_q.size() > 0 &&
              (in_dir != run_q[0] || run_q.size() == 31)) begin
            do_push = 1;
            t = tk(0, run_q[0], run_q.size());
            run_q.delete();
          end
          run_q.push_back(in_dir);
        end else if (run_q.size() > 0) begin
          do_push = 1;
          t = tk(1, run_q[0], run_q.size());
          run_q.delete();
        end
        was_full = (mq.size() == 8);
        do_pop = out_ready && mq.size() > 0;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          if (was_full && !do_pop) m_ov = 1;
          else mq.push_back(t);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", int'(out_valid), int'(mq.size() != 0));
      chk("token", int'({out_last, out_dir, out_len}),
          mq.size() != 0 ? int'(mq[0]) : 0);
      chk("overflow", int'(overflow), int'(m_ov));
      chk("busy", int'(busy), int'(mq.size() != 0 || run_q.size() != 0));
      if (out_valid && out_ready) got.push_back({out_last, out_dir, out_len});
    end
  end

  task automatic beat(input bit v, input int d);
    in_valid = v;
    in_dir = 2'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    out_ready = 1;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({nm, "_tok"}, int'(got[i]), int'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_outs"},
        int'({out_valid, out_dir, out_len, out_last, overflow, busy}), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0;
    in_dir = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    @(posedge clk);
    #1;

    out_ready = 1;
    beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 1);
    chk("basic_first_valid", int'(out_valid), 1);
    chk("basic_first_tok", int'({out_last, out_dir, out_len}),
        int'(tk(0, 0, 3)));
    beat(1, 1); beat(1, 2); beat(0, 0);
    drain();
    chk("basic_busy_low", int'(busy), 0);
    exp_q = '{8'h03, 8'h22, 8'hC1};
    check_log("basic");

    beat(1, 3); beat(0, 0);
    drain();
    exp_q.push_back(tk(1, 3, 1));
    check_log("single");
    chk("single_ovf", int'(overflow), 0);

    for (int i = 0; i < 33; i++) beat(1, 0);
    beat(0, 0);
    drain();
    exp_q = '{8'h1F, 8'h82};
    check_log("sat");

    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      beat(1, i % 2);
      if (i == 8) chk("ovf_before", int'(overflow), 0);
      if (i == 9) chk("ovf_after", int'(overflow), 1);
    end
    beat(0, 0);
    drain();
    for (int i = 0; i < 8; i++) exp_q.push_back(tk(0, i % 2, 1));
    check_log("ovf");
    chk("ovf_sticky", int'(overflow), 1);
    pulse_reset();
    check_zero("ovf_cleared");

    out_ready = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 9) out_ready = 1;
      beat(1, i % 2);
    end
    beat(0, 0);
    drain();
    chk("full_pop_ovf", int'(overflow), 0);
    for (int i = 0; i < 13; i++) exp_q.push_back(tk(0, i % 2, 1));
    exp_q.push_back(tk(1, 1, 1));
    check_log("full_pop");

    out_ready = 1;
    beat(1, 0); beat(1, 0); beat(0, 0); beat(1, 1); beat(0, 0);
    drain();
    exp_q = '{8'h82, 8'hA1};
    check_log("b2b");

    out_ready = 0;
    beat(1, 0); beat(1, 1); beat(1, 2);
    chk("pre_reset_valid", int'(out_valid), 1);
    #2;
    rst_n = 0;
    #1;
    check_zero("mid_reset");
    in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    got.delete();
    beat(1, 2); beat(0, 0);
    drain();
    exp_q.push_back(tk(1, 2, 1));
    check_log("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/path_rle_encoder.md
# path_rle_encoder

- Sits directly downstream of the maze solver and consumes its serial direction stream: one 2-bit move per cycle while valid is high, no backpressure.
- Compresses the stream into run-length tokens (direction, run length, last flag).
- Buffers tokens in an internal FIFO, so a consumer with a ready handshake can drain them at its own pace.

## Interface

Parameters:
- DIR_WIDTH, 2, direction code width (0 RIGHT, 1 DOWN, 2 LEFT, 3 UP)
- LEN_WIDTH, 5, run-length field width; maximum run MAX_LEN = 2^LEN_WIDTH-1 (31)
- FIFO_DEPTH, 8, token FIFO entries (power of two)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  direction beat valid; contiguous high cycles form one burst (one path)
- in_dir  input  DIR_WIDTH  direction of current beat
- out_ready  input  1  consumer accepts token this cycle
- out_valid  output  1  token available at FIFO head
- out_dir  output  DIR_WIDTH  token direction
- out_len  output  LEN_WIDTH  token run length, 1..MAX_LEN
- out_last  output  1  token is final run of its burst
- overflow  output  1  sticky: a token was dropped because FIFO was full
- busy  output  1  run open or FIFO non-empty

## Operation

- FSM has two states: IDLE and RUN. Run accumulator holds cur_dir and cur_len.
- **IDLE:**
  - in_valid=1: load cur_dir=in_dir, cur_len=1; go to RUN.
  - in_valid=0: stay in IDLE.
- **RUN, in_valid=1, in_dir==cur_dir, cur_len<MAX_LEN:** cur_len+1.
- **RUN, in_valid=1, in_dir!=cur_dir or cur_len==MAX_LEN:**
  - Push {0, cur_dir, cur_len}.
  - Load cur_dir=in_dir, cur_len=1.
  - Stay in RUN.
- **RUN, in_valid=0:** push {1, cur_dir, cur_len}; go to IDLE.
- Saturation: the beat that would exceed MAX_LEN closes the current run (out_last=0) and starts a new run of length 1 in the same direction.
- FIFO:
  - Registered storage with first-word fall-through.
  - out_valid = !empty. Pop when out_valid && out_ready.
  - out_dir, out_len and out_last are forced to 0 while out_valid=0.
- Push and pop in the same cycle:
  - Always legal, including when the FIFO is full; count is unchanged and the pushed token is stored.
- Push while full without a pop:
  - Token is dropped and overflow is set.
  - overflow stays set until rst_n. Other behaviour is unchanged.
- Pop while empty: no effect.
- busy = (state==RUN) || !empty.
- Widths: cur_len is LEN_WIDTH bits and never wraps. FIFO pointers are log2(FIFO_DEPTH) bits and wrap. Count is log2(FIFO_DEPTH)+1 bits.

## Timing

- Reset values (asserted asynchronously, all at once):
  - Outputs: out_valid, out_dir, out_len, out_last, overflow, busy all 0.
  - Internal: FSM in IDLE, FIFO empty.
- Reset during RUN or with FIFO contents: the open run and all buffered tokens are discarded. The first post-reset burst encodes from scratch.
- Input is sampled on every edge, with no stall. The block accepts one beat per cycle indefinitely.
- Token latency:
  - A run closed at edge k is visible (out_valid=1, fields valid) after edge k, provided the FIFO was empty.
  - The last token of a burst appears after the edge that samples the first in_valid=0 cycle.
- Handshake:
  - A token is consumed at the edge where out_valid && out_ready.
  - The next token, if any, is presented after that edge.
  - Sustained throughput is one token per cycle.
- Bursts:
  - A minimum gap of one in_valid=0 cycle separates bursts.
  - A new burst starting the cycle after the closing push loads normally from IDLE.
- busy falls the cycle after the last token is popped, with the FSM in IDLE.

## Test plan

- **Basic burst:** burst R,R,R,D,D,L, then in_valid=0, out_ready=1 → tokens (dir0,len3,last0), (dir1,len2,last0), (dir2,len1,last1). The first token is valid the cycle after the D beat edge. busy returns to 0.
- **Single-beat burst:** UP → one token (dir3,len1,last1). overflow stays 0.
- **Saturation:** 33 consecutive RIGHT beats → (dir0,len31,last0), (dir0,len2,last1).
- **Overflow:** out_ready=0, burst alternating R,D for 10 beats (9 closes plus the end push, 10 pushes in total).
  - The first 8 tokens are stored.
  - overflow rises after the 9th push edge.
  - out_ready=1 then drains exactly 8 tokens, each len1, all last0; overflow remains 1.
- **Full with simultaneous pop:** fill the FIFO to 8 entries, then hold out_ready=1 while pushes continue. No drop occurs, overflow stays 0, and order is preserved.
- **Back-to-back bursts and reset:**
  - Bursts R,R / one idle cycle / D → (dir0,len2,last1), (dir1,len1,last1).
  - Then pulse rst_n low mid-burst with 2 tokens buffered → all outputs 0 immediately. A subsequent burst L → (dir2,len1,last1).
